// File: rtl/tdm_codec_port.sv
// tdm_codec_port
//   N-channel I2S / left-justified TDM serial port. Derives MCLK, BCLK and
//   LRCLK from audio_clk, serialises CHANNELS x WIDTH play samples MSB-first
//   onto DAC_SDATA and assembles ADC_SDATA into RecData.
//
//   Ports
//     audio_clk   in   sole clock, rising edge
//     reset       in   synchronous, active-low
//     Enable      in   1 = run frames, 0 = stop at the next frame boundary
//     Fmt         in   0 = I2S (1-bit delay), 1 = left-justified; taken at NewFrame
//     PlayData    in   channel c at [c*WIDTH +: WIDTH]
//     ADC_SDATA   in   serial capture data
//     MCLK        out  free-running master clock
//     BCLK        out  bit clock
//     LRCLK       out  frame sync, high for the second half of the frame
//     DAC_SDATA   out  serial play data
//     NewFrame    out  1-cycle pulse, PlayData/Fmt taken on the edge raising it
//     RecData     out  last complete captured frame, same packing as PlayData
//     RecValid    out  1-cycle pulse when RecData updates
//     dbg_state_o out  FSM state (0 = IDLE, 1 = RUN)
//
//   Strobes: NewFrame and RecValid are single-cycle, no back-pressure; the
//   consumer must act in the cycle the pulse is high.
module tdm_codec_port #(
  parameter int WIDTH    = 24,
  parameter int SLOT     = 32,
  parameter int CHANNELS = 2,
  parameter int BCLK_DIV = 4,
  parameter int MCLK_DIV = 2
) (
  input  logic                      audio_clk,
  input  logic                      reset,
  input  logic                      Enable,
  input  logic                      Fmt,
  input  logic [CHANNELS*WIDTH-1:0] PlayData,
  input  logic                      ADC_SDATA,
  output logic                      MCLK,
  output logic                      BCLK,
  output logic                      LRCLK,
  output logic                      DAC_SDATA,
  output logic                      NewFrame,
  output logic [CHANNELS*WIDTH-1:0] RecData,
  output logic                      RecValid,
  output logic                      dbg_state_o
);
  localparam int F     = CHANNELS * SLOT;
  localparam int DW    = CHANNELS * WIDTH;
  localparam int BW    = $clog2(F);
  localparam int DVW   = $clog2(BCLK_DIV);
  localparam int IW    = (DW > 1) ? $clog2(DW) : 1;
  localparam int MHALF = MCLK_DIV / 2;
  localparam int MW    = (MHALF > 1) ? $clog2(MHALF) : 1;

  localparam logic [BW-1:0]  BIT_LAST  = BW'(F - 1);
  localparam logic [BW-1:0]  BIT_HALF  = BW'(F / 2);
  // Frame position of the last real bit: LSB of channel CHANNELS-1.
  localparam logic [BW-1:0]  CAP_LAST  = BW'((CHANNELS - 1) * SLOT + WIDTH - 1);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(BCLK_DIV - 1);
  localparam logic [DVW-1:0] DIV_HALF  = DVW'(BCLK_DIV / 2);
  localparam logic [MW-1:0]  MCNT_LAST = MW'(MHALF - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [DVW-1:0] bdiv_q, bdiv_d;
  logic [BW-1:0]  bitcnt_q, bitcnt_d;
  logic [DW-1:0]  play_q, play_d;
  logic           fmt_q, fmt_d;
  logic [DW-1:0]  shadow_q, shadow_d;
  logic           first_q;
  logic [MW-1:0]  mcnt_q;

  logic           start;
  logic           play_wrap, cap_wrap, sample_en, last_bit, dac_next;
  logic [BW-1:0]  q_play, q_cap;
  logic [IW:0]    play_sel, cap_sel;

  // Maps a frame position to {valid, flat bit index}; valid=0 for pad bits.
  function automatic logic [IW:0] slot_index(input logic [BW-1:0] q);
    int          s;
    int          b;
    logic [IW:0] r;
    s = int'(q) / SLOT;
    b = int'(q) % SLOT;
    r = '0;
    if (b < WIDTH) r = {1'b1, IW'(s * WIDTH + WIDTH - 1 - b)};
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    bdiv_d   = bdiv_q;
    bitcnt_d = bitcnt_q;
    start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          state_d  = ST_RUN;
          bdiv_d   = '0;
          bitcnt_d = '0;
          start    = 1'b1;
        end
      end
      ST_RUN: begin
        if (bdiv_q == DIV_LAST) begin
          bdiv_d = '0;
          if (bitcnt_q == BIT_LAST) begin
            bitcnt_d = '0;
            // The frame always completes; Enable only decides whether another starts.
            if (Enable) start = 1'b1;
            else        state_d = ST_IDLE;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end else begin
          bdiv_d = bdiv_q + DVW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    play_d = start ? PlayData : play_q;
    fmt_d  = start ? Fmt : fmt_q;

    // Play side looks at the position being entered. In I2S, frame bit 0
    // still carries the last bit of the previous frame, so it indexes the
    // old latched data (play_q) rather than the data just taken.
    play_wrap = !fmt_d && (bitcnt_d == '0);
    q_play    = play_wrap ? BIT_LAST : (fmt_d ? bitcnt_d : bitcnt_d - BW'(1));
    play_sel  = slot_index(q_play);
    dac_next  = 1'b0;
    if (play_sel[IW]) dac_next = play_wrap ? play_q[play_sel[IW-1:0]] : play_d[play_sel[IW-1:0]];

    // Capture side samples at BCLK rise using the current position. The
    // wrapped I2S sample right after a restart belongs to no captured frame.
    cap_wrap  = !fmt_q && (bitcnt_q == '0);
    q_cap     = cap_wrap ? BIT_LAST : (fmt_q ? bitcnt_q : bitcnt_q - BW'(1));
    cap_sel   = slot_index(q_cap);
    sample_en = (state_q == ST_RUN) && (bdiv_q == DIV_HALF) &&
                !(cap_wrap && first_q) && cap_sel[IW];
    last_bit  = sample_en && (q_cap == CAP_LAST);
    shadow_d  = shadow_q;
    if (sample_en) shadow_d[cap_sel[IW-1:0]] = ADC_SDATA;
  end

  always_ff @(posedge audio_clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bdiv_q    <= '0;
      bitcnt_q  <= '0;
      play_q    <= '0;
      fmt_q     <= 1'b0;
      shadow_q  <= '0;
      first_q   <= 1'b0;
      mcnt_q    <= '0;
      MCLK      <= 1'b0;
      BCLK      <= 1'b0;
      LRCLK     <= 1'b0;
      DAC_SDATA <= 1'b0;
      NewFrame  <= 1'b0;
      RecData   <= '0;
      RecValid  <= 1'b0;
    end else begin
      if (mcnt_q == MCNT_LAST) begin
        mcnt_q <= '0;
        MCLK   <= ~MCLK;
      end else begin
        mcnt_q <= mcnt_q + MW'(1);
      end

      state_q  <= state_d;
      bdiv_q   <= bdiv_d;
      bitcnt_q <= bitcnt_d;
      play_q   <= play_d;
      fmt_q    <= fmt_d;
      shadow_q <= shadow_d;

      if (start && (state_q == ST_IDLE))                    first_q <= 1'b1;
      else if ((state_q == ST_RUN) && (bdiv_q == DIV_HALF)) first_q <= 1'b0;

      NewFrame <= start;
      BCLK     <= (state_d == ST_RUN) && (bdiv_d >= DIV_HALF);
      LRCLK    <= (state_d == ST_RUN) && (bitcnt_d >= BIT_HALF);
      // Data only moves on the BCLK falling edge (bdiv back to 0).
      if (state_d != ST_RUN)  DAC_SDATA <= 1'b0;
      else if (bdiv_d == '0)  DAC_SDATA <= dac_next;

      RecValid <= last_bit;
      if (last_bit) RecData <= shadow_d;
    end
  end

  assign dbg_state_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_tdm_codec_port.sv
// Directed bench for tdm_codec_port: default stereo instance plus a
// 4-channel 16/16 instance (its ADC looped back from its DAC).
module tb_tdm_codec_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, fmt = 1'b0, loop_en = 1'b0;
  logic [47:0] pd = '0;
  logic        adc;
  logic        mclk, bclk, lrclk, dac, nf, rv, dbg;
  logic [47:0] rd;

  logic        en4 = 1'b0, fmt4 = 1'b0;
  logic [63:0] pd4 = '0;
  logic        adc4;
  logic        mclk4, bclk4, lrclk4, dac4, nf4, rv4, dbg4;
  logic [63:0] rd4;

  int checks = 0;
  int passes = 0;
  logic [47:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign adc  = loop_en ? dac : 1'b0;
  assign adc4 = dac4;

  tdm_codec_port dut (
    .audio_clk(clk), .reset(rst_n), .Enable(en), .Fmt(fmt), .PlayData(pd),
    .ADC_SDATA(adc), .MCLK(mclk), .BCLK(bclk), .LRCLK(lrclk), .DAC_SDATA(dac),
    .NewFrame(nf), .RecData(rd), .RecValid(rv), .dbg_state_o(dbg)
  );

  tdm_codec_port #(.WIDTH(16), .SLOT(16), .CHANNELS(4)) dut4 (
    .audio_clk(clk), .reset(rst_n), .Enable(en4), .Fmt(fmt4), .PlayData(pd4),
    .ADC_SDATA(adc4), .MCLK(mclk4), .BCLK(bclk4), .LRCLK(lrclk4), .DAC_SDATA(dac4),
    .NewFrame(nf4), .RecData(rd4), .RecValid(rv4), .dbg_state_o(dbg4)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; en4 = 1'b0; loop_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_newframe(input bit sel, input string tag);
    int n;
    n = 0;
    while (((sel ? nf4 : nf) !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((sel ? nf4 : nf) !== 1'b1)
      $display("FAIL %s_newframe: NewFrame=%b after %0d cycles, required 1", tag, sel ? nf4 : nf, n);
    else passes++;
  endtask

  // Starts at the NewFrame cycle (frame cycle 0), ends at frame cycle 256.
  task automatic capture_frame(input bit sel, output logic [63:0] dac_v, output logic [63:0] lr_v,
                               output int bclk_err, output int nf_extra, output int rv_cnt,
                               output logic nf_end);
    dac_v = '0; lr_v = '0; bclk_err = 0; nf_extra = 0; rv_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      logic d, l, b, n, r;
      d = sel ? dac4 : dac;
      l = sel ? lrclk4 : lrclk;
      b = sel ? bclk4 : bclk;
      n = sel ? nf4 : nf;
      r = sel ? rv4 : rv;
      if ((c % 4) == 1) begin
        dac_v[63 - c / 4] = d;
        lr_v[63 - c / 4]  = l;
      end
      if (b !== 1'((c % 4) >= 2)) bclk_err++;
      if ((c > 0) && (n === 1'b1)) nf_extra++;
      if (r === 1'b1) rv_cnt++;
      @(negedge clk);
    end
    nf_end = sel ? nf4 : nf;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; en4 = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({mclk, bclk, lrclk, dac, nf, rv, dbg} !== 7'b0)
      $display("FAIL reset_outs: got %b required 0000000", {mclk, bclk, lrclk, dac, nf, rv, dbg});
    else passes++;
    checks++;
    if (rd !== 48'h0) $display("FAIL reset_recdata: got %h required 0", rd);
    else passes++;
    checks++;
    if ({mclk4, bclk4, lrclk4, dac4, nf4, rv4, dbg4} !== 7'b0 || rd4 !== 64'h0)
      $display("FAIL reset_outs4: got %b/%h required 0/0", {mclk4, bclk4, lrclk4, dac4, nf4, rv4, dbg4}, rd4);
    else passes++;
    en = 1'b0; en4 = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mclk !== 1'b1) $display("FAIL mclk_first: got %b required 1", mclk); else passes++;
    @(negedge clk);
    checks++;
    if (mclk !== 1'b0) $display("FAIL mclk_second: got %b required 0", mclk); else passes++;
    @(negedge clk);
    checks++;
    if (mclk !== 1'b1) $display("FAIL mclk_third: got %b required 1", mclk); else passes++;
    checks++;
    if ({bclk, lrclk, dac, nf, dbg} !== 5'b0)
      $display("FAIL idle_hold: got %b required 00000", {bclk, lrclk, dac, nf, dbg});
    else passes++;
  endtask

  task automatic test_stereo(input logic fmt_v, input string tag, input logic [63:0] exp_dac);
    logic [63:0] dv, lv;
    int          be, ne, rc;
    logic        nend;
    do_reset();
    fmt = fmt_v;
    pd  = {24'h3C3C3C, 24'hA5A5A5};
    en  = 1'b1;
    wait_newframe(0, tag);
    capture_frame(0, dv, lv, be, ne, rc, nend);
    checks++;
    if (dv !== exp_dac) $display("FAIL %s_dac: got %h required %h", tag, dv, exp_dac); else passes++;
    checks++;
    if (lv !== {32'h0, 32'hFFFF_FFFF}) $display("FAIL %s_lrclk: got %h required 00000000ffffffff", tag, lv);
    else passes++;
    checks++;
    if (be !== 0) $display("FAIL %s_bclk: %0d bad BCLK cycles, required 0", tag, be); else passes++;
    checks++;
    if (ne !== 0 || nend !== 1'b1)
      $display("FAIL %s_period: extra NewFrame %0d, NewFrame at 256 = %b, required 0/1", tag, ne, nend);
    else passes++;
    checks++;
    if (rc !== 1) $display("FAIL %s_recvalid: got %0d pulses required 1", tag, rc); else passes++;
    en = 1'b0;
  endtask

  task automatic test_tdm4();
    logic [63:0] dv, lv;
    int          be, ne, rc;
    logic        nend;
    do_reset();
    pd4 = {16'h0001, 16'h00F0, 16'h1234, 16'h8000};
    en4 = 1'b1;
    wait_newframe(1, "tdm4");
    capture_frame(1, dv, lv, be, ne, rc, nend);
    checks++;
    if (dv !== {1'b0, 16'h8000, 16'h1234, 16'h00F0, 15'h0000})
      $display("FAIL tdm4_dac_f1: got %h", dv);
    else passes++;
    checks++;
    if (lv !== {32'h0, 32'hFFFF_FFFF}) $display("FAIL tdm4_lrclk: got %h required 00000000ffffffff", lv);
    else passes++;
    checks++;
    if (rc !== 0 || nend !== 1'b1)
      $display("FAIL tdm4_first: RecValid %0d required 0, NewFrame at 256 = %b required 1", rc, nend);
    else passes++;
    capture_frame(1, dv, lv, be, ne, rc, nend);
    checks++;
    if (dv !== {1'b1, 16'h8000, 16'h1234, 16'h00F0, 15'h0000})
      $display("FAIL tdm4_dac_f2: got %h", dv);
    else passes++;
    checks++;
    if (rc !== 1 || be !== 0) $display("FAIL tdm4_second: RecValid %0d required 1, bad BCLK %0d", rc, be);
    else passes++;
    checks++;
    if (rd4 !== 64'h0001_00F0_1234_8000) $display("FAIL tdm4_recdata: got %h required 000100f012348000", rd4);
    else passes++;
    en4 = 1'b0;
  endtask

  task automatic test_loopback(input logic fmt_v);
    int          nf_cnt, rv_cnt;
    logic [47:0] exp;
    do_reset();
    loop_en = 1'b1;
    fmt = fmt_v;
    pd  = {24'($urandom), 24'($urandom)};
    exp_q.delete();
    nf_cnt = 0; rv_cnt = 0;
    en = 1'b1;
    wait_newframe(0, "loop");
    for (int c = 0; c <= 1032; c++) begin
      if (nf === 1'b1) begin
        exp_q.push_back(pd);
        nf_cnt++;
        pd = {24'($urandom), 24'($urandom)};
      end
      if (rv === 1'b1) begin
        rv_cnt++;
        checks++;
        if (exp_q.size() == 0) $display("FAIL loop_rec_fmt%0d: RecValid with nothing expected, got %h", fmt_v, rd);
        else begin
          exp = exp_q.pop_front();
          if (rd !== exp) $display("FAIL loop_rec_fmt%0d: got %h required %h", fmt_v, rd, exp);
          else passes++;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nf_cnt !== 5 || rv_cnt !== 4)
      $display("FAIL loop_counts_fmt%0d: NewFrame %0d RecValid %0d, required 5 and 4", fmt_v, nf_cnt, rv_cnt);
    else passes++;
    en = 1'b0;
  endtask

  task automatic test_enable_on_newframe();
    logic b254;
    int   nf_cnt, bclk_hi;
    do_reset();
    fmt = 1'b1;
    en  = 1'b1;
    wait_newframe(0, "drop_nf");
    en = 1'b0;
    b254 = 1'b0; nf_cnt = 0; bclk_hi = 0;
    for (int c = 0; c <= 300; c++) begin
      if (c == 254) b254 = bclk;
      if ((c > 0) && (nf === 1'b1)) nf_cnt++;
      if ((c >= 256) && (bclk !== 1'b0)) bclk_hi++;
      @(negedge clk);
    end
    checks++;
    if (b254 !== 1'b1) $display("FAIL drop_nf_full_frame: BCLK at cycle 254 = %b required 1", b254);
    else passes++;
    checks++;
    if (nf_cnt !== 0 || bclk_hi !== 0 || dbg !== 1'b0)
      $display("FAIL drop_nf_idle: NewFrame %0d BCLK-high %0d state %b, required 0/0/0", nf_cnt, bclk_hi, dbg);
    else passes++;
  endtask

  task automatic test_stop_midrun();
    logic n256, b510, l510;
    int   nf_late, idle_err;
    do_reset();
    fmt = 1'b0;
    en  = 1'b1;
    wait_newframe(0, "stop");
    n256 = 1'b0; b510 = 1'b0; l510 = 1'b0; nf_late = 0; idle_err = 0;
    for (int c = 0; c <= 800; c++) begin
      if (c == 400) en = 1'b0;
      if (c == 256) n256 = nf;
      if (c == 510) begin b510 = bclk; l510 = lrclk; end
      if ((c > 256) && (nf === 1'b1)) nf_late++;
      if ((c >= 512) && ((bclk | lrclk | dac) !== 1'b0)) idle_err++;
      @(negedge clk);
    end
    checks++;
    if (n256 !== 1'b1) $display("FAIL stop_second_frame: NewFrame at 256 = %b required 1", n256); else passes++;
    checks++;
    if ({b510, l510} !== 2'b11) $display("FAIL stop_completes: BCLK/LRCLK at 510 = %b required 11", {b510, l510});
    else passes++;
    checks++;
    if (nf_late !== 0 || idle_err !== 0 || dbg !== 1'b0)
      $display("FAIL stop_idle: late NewFrame %0d, active outputs %0d, state %b, required 0/0/0", nf_late, idle_err, dbg);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    int rv_cnt;
    do_reset();
    loop_en = 1'b1;
    fmt = 1'b0;
    pd  = {24'($urandom), 24'($urandom)} | 48'h1;
    en  = 1'b1;
    wait_newframe(0, "rstmid");
    repeat (256 + 160) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mclk, bclk, lrclk, dac, nf, rv, dbg} !== 7'b0 || rd !== 48'h0)
      $display("FAIL rstmid_outs: got %b/%h required 0/0", {mclk, bclk, lrclk, dac, nf, rv, dbg}, rd);
    else passes++;
    en = 1'b0;
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (rv === 1'b1) rv_cnt++;
      @(negedge clk);
    end
    checks++;
    if (rv_cnt !== 0 || rd !== 48'h0) $display("FAIL rstmid_norec: RecValid %0d RecData %h, required 0/0", rv_cnt, rd);
    else passes++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stereo(1'b0, "i2s", {1'b0, 24'hA5A5A5, 8'h00, 24'h3C3C3C, 7'h00});
    test_stereo(1'b1, "lj",  {24'hA5A5A5, 8'h00, 24'h3C3C3C, 8'h00});
    test_tdm4();
    test_loopback(1'b0);
    test_loopback(1'b1);
    test_enable_on_newframe();
    test_stop_midrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
